out_port_arb: RTL
=================

OUT_PORT_ARB -- requirements
Module: out_port_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 5, meaning the number of competing input ports (N/E/S/W/local), legal range 2..8.
REQ-002 SHALL have parameter PYLD_W, default 32, meaning the flit payload width in bits.
REQ-003 SHALL have clk  input  1  clock; all state is updated on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have valid_i  input  NUM_IN  per-port flit valid.
REQ-006 SHALL have ready_o  output  NUM_IN  per-port flit accept.
REQ-007 SHALL have payload_i  input  NUM_IN*PYLD_W  per-port flit payload; port k occupies bits [k*PYLD_W +: PYLD_W].
REQ-008 SHALL have last_i  input  NUM_IN  per-port tail-flit marker.
REQ-009 SHALL have valid_o  output  1  flit valid toward the downstream output buffer.
REQ-010 SHALL have ready_i  input  1  accept from the downstream output buffer.
REQ-011 SHALL have payload_o  output  PYLD_W  selected payload.
REQ-012 SHALL have last_o  output  1  selected tail marker.
REQ-013 SHALL have grant_o  output  NUM_IN  one-hot (or zero) current grant.

Function
REQ-014 SHALL implement states IDLE and LOCKED, plus a round-robin pointer ptr (clog2(NUM_IN) bits) and a lock index lock_idx.
REQ-015 In IDLE, the grant SHALL go combinationally to the first requesting port at or after ptr, in increasing index order with wrap; grant_o SHALL be zero if no valid_i is set.
REQ-016 In LOCKED, the grant SHALL be one-hot on lock_idx regardless of other requests, and grant_o SHALL remain set even if valid_i[lock_idx] is 0 (bubble).
REQ-017 valid_o SHALL equal valid_i of the granted port, and payload_o/last_o SHALL equal that port's fields; with no grant, valid_o=0, payload_o=0 and last_o=0.
REQ-018 ready_o[k] SHALL equal ready_i AND grant_o[k]; non-granted ports see 0.
REQ-019 A transfer SHALL occur on each cycle where valid_o && ready_i, giving zero-cycle latency through the block.
REQ-020 In IDLE, a transfer with last=0 SHALL go to LOCKED with lock_idx set to the granted port.
REQ-021 A transfer with last=1 (single-flit in IDLE, or tail in LOCKED) SHALL leave or stay in IDLE with ptr set to granted+1 modulo NUM_IN; wrap from NUM_IN-1 is to 0.
REQ-022 ptr SHALL NOT change on cycles without a tail transfer.
REQ-023 A combinational path SHALL NOT exist from ready_i to valid_o or grant_o.
REQ-024 In IDLE, the grant MAY change between cycles while ready_i=0; in LOCKED it SHALL NOT change.

Reset
REQ-025 On asynchronous reset, the block SHALL enter IDLE with ptr=0 and lock_idx=0.
REQ-026 Outputs SHALL then follow REQ-015..018, so reset with valid_i=0 gives valid_o=0, grant_o=0 and ready_o=0.
REQ-027 Reset during LOCKED SHALL abandon the packet, and the partially sent worm SHALL NOT be resumed.

Configuration
REQ-028 With macro OUT_PORT_ARB_PKT_CNT_EN defined, the block SHALL add output pkt_cnt_o  output  16  count of tail transfers.
REQ-029 pkt_cnt_o SHALL reset to 0, increment by 1 per tail transfer, and wrap from 0xFFFF to 0.
REQ-030 Without OUT_PORT_ARB_PKT_CNT_EN, the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-031 Shared package maze_pkg SHALL hold the default NUM_IN/PYLD_W constants and the arbiter state enum (ARB_IDLE, ARB_LOCKED).
REQ-032 The round-robin priority picker (request vector + ptr -> one-hot grant) SHALL be sub-module rr_pick, reusable by other router ports.

Verification
REQ-033 Reset, then valid_i=5'b10100 with single-flit packets and ready_i=1 -> grant order port2, port4, port2; ptr is 3 after the first.
REQ-034 Port1 sends a 3-flit packet while port3 requests throughout -> port1's 3 flits go out contiguously, then port3 is granted; ptr=2 after port1's tail.
REQ-035 LOCKED on port0 with valid_i[0]=0 for 2 cycles, port2 valid -> valid_o=0, grant_o=5'b00001, ready_o[2]=0; lock held.
REQ-036 ready_i=0 for 4 cycles with port4 head pending -> no transfer, state IDLE, payload_o stable; ready_i=1 -> transfer, then ptr wraps to 0 after a single-flit packet.
REQ-037 rst_n asserted mid-packet on port3 -> next cycle IDLE, ptr=0; with OUT_PORT_ARB_PKT_CNT_EN defined, pkt_cnt_o returns to 0 and counts 0xFFFF->0 after 65536 tails.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared constants and types for the maze router output ports.
//   MAZE_NUM_IN  - default number of competing input ports (N/E/S/W/local)
//   MAZE_PYLD_W  - default flit payload width in bits
//   PKT_CNT_W    - width of the optional tail-transfer counter
//   arb_state_t  - output-port arbiter state (ARB_IDLE, ARB_LOCKED)
package maze_pkg;

    localparam int unsigned MAZE_NUM_IN = 5;
    localparam int unsigned MAZE_PYLD_W = 32;
    localparam int unsigned PKT_CNT_W   = 16;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority picker.
// Grants the first set bit of req at or after index ptr, in increasing
// index order with wrap-around. Output is one-hot, or zero when req is zero.
//   req - request vector (N bits)
//   ptr - highest-priority index, must be < N
//   gnt - one-hot grant (N bits)
module rr_pick
    import maze_pkg::*;
#(
    parameter  int unsigned N  = MAZE_NUM_IN,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr + off, folded back into 0..N-1 (one subtraction suffices)
            sum = {1'b0, ptr} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arb.sv
// out_port_arb: wormhole output-port arbiter with round-robin fairness.
// In IDLE the grant goes to the first requester at or after ptr; a head
// flit without last locks the port to that input until its tail transfers.
// Data path is combinational (zero-cycle latency); grant never depends on
// ready_i.
//   clk, rst_n  - clock, asynchronous active-low reset
//   valid_i     - per-port flit valid          ready_o   - per-port accept
//   payload_i   - per-port payload, port k at [k*PYLD_W +: PYLD_W]
//   last_i      - per-port tail marker
//   valid_o, payload_o, last_o - selected flit toward output buffer
//   ready_i     - output buffer accept
//   grant_o     - one-hot (or zero) current grant
//   pkt_cnt_o   - tail-transfer count, only with OUT_PORT_ARB_PKT_CNT_EN
module out_port_arb
    import maze_pkg::*;
#(
    parameter int unsigned NUM_IN = MAZE_NUM_IN,
    parameter int unsigned PYLD_W = MAZE_PYLD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        valid_i,
    output logic [NUM_IN-1:0]        ready_o,
    input  logic [NUM_IN*PYLD_W-1:0] payload_i,
    input  logic [NUM_IN-1:0]        last_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [PYLD_W-1:0]        payload_o,
    output logic                     last_o,
    output logic [NUM_IN-1:0]        grant_o
`ifdef OUT_PORT_ARB_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0]     pkt_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(NUM_IN);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     lock_q, lock_d;
    logic [NUM_IN-1:0] rr_gnt;
    logic [PW-1:0]     gidx;
    logic              xfer;

    rr_pick #(
        .N (NUM_IN)
    ) u_rr_pick (
        .req (valid_i),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    assign xfer = valid_o & ready_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (xfer) begin
            if (last_o) begin
                state_d = ARB_IDLE;
                ptr_d   = (gidx == PW'(NUM_IN-1)) ? '0 : gidx + PW'(1);
            end else if (state_q == ARB_IDLE) begin
                state_d = ARB_LOCKED;
                lock_d  = gidx;
            end
        end
    end

    // Outputs: grant, selected flit fields and per-port accept
    always_comb begin
        grant_o = '0;
        if (state_q == ARB_LOCKED) begin
            grant_o[lock_q] = 1'b1;
        end else begin
            grant_o = rr_gnt;
        end
        valid_o   = 1'b0;
        payload_o = '0;
        last_o    = 1'b0;
        gidx      = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (grant_o[k]) begin
                valid_o   = valid_i[k];
                payload_o = payload_i[k*PYLD_W +: PYLD_W];
                last_o    = last_i[k];
                gidx      = PW'(k);
            end
        end
        ready_o = {NUM_IN{ready_i}} & grant_o;
    end

`ifdef OUT_PORT_ARB_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_o <= '0;
        end else if (xfer && last_o) begin
            pkt_cnt_o <= pkt_cnt_o + PKT_CNT_W'(1);
        end
    end
`endif

endmodule
